// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and its consumer.
// master = consumer side (issues pops), slave = FIFO side.
interface fifo_uart_tx_if #(
  parameter int FIFO_WIDTH = 4
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;

  modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serialises each as a UART frame:
// start bit, data LSB first, optional even parity, stop bit.
module fifo_uart_tx #(
  parameter int FIFO_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  fifo_uart_tx_if.master   fifo,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(FIFO_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [BW-1:0]         baud, baud_nx;
  logic [NW-1:0]         bitn, bitn_nx;
  logic [FIFO_WIDTH-1:0] shift, shift_nx;
  logic                  par, par_nx;
  logic                  tx_nx, rd_en_nx, done_nx;
  logic                  baud_wrap;

  assign baud_wrap = (baud == BAUD_LAST);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bitn_nx  = bitn;
    shift_nx = shift;
    par_nx   = par;
    case (state)
      IDLE:  if (enable && !fifo.fifo_empty) state_nx = POP;
      POP:   state_nx = fifo.fifo_empty ? IDLE : LOAD;
      LOAD: begin
        shift_nx = fifo.fifo_rd_data;
        par_nx   = ^fifo.fifo_rd_data;
        baud_nx  = '0;
        bitn_nx  = '0;
        state_nx = START;
      end
      START: begin
        if (baud_wrap) begin
          baud_nx  = '0;
          state_nx = DATA;
        end else baud_nx = baud + 1'b1;
      end
      DATA: begin
        if (baud_wrap) begin
          baud_nx  = '0;
          shift_nx = shift >> 1;
          if (bitn == BIT_LAST) begin
            bitn_nx  = '0;
            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else bitn_nx = bitn + 1'b1;
        end else baud_nx = baud + 1'b1;
      end
      PARITY: begin
        if (baud_wrap) begin
          baud_nx  = '0;
          state_nx = STOP;
        end else baud_nx = baud + 1'b1;
      end
      STOP: begin
        if (baud_wrap) begin
          baud_nx  = '0;
          state_nx = IDLE;
        end else baud_nx = baud + 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Registered outputs are derived from the next state so that each one
    // reflects the state actually occupied during the following cycle.
    rd_en_nx = (state_nx == POP);
    done_nx  = (state_nx == STOP) && (baud_nx == BAUD_LAST);
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      PARITY:  tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      baud            <= '0;
      bitn            <= '0;
      shift           <= '0;
      par             <= 1'b0;
      tx              <= 1'b1;
      fifo.fifo_rd_en <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_nx;
      baud            <= baud_nx;
      bitn            <= bitn_nx;
      shift           <= shift_nx;
      par             <= par_nx;
      tx              <= tx_nx;
      fifo.fifo_rd_en <= rd_en_nx;
      frame_done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (default, parity, 1 clk/bit) each fed
// by a behavioural FIFO; received frames are checked against a word scoreboard.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic tx0, tx1, tx2, busy0, busy1, busy2, fd0, fd1, fd2;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx_if #(.FIFO_WIDTH(4)) if0 ();
  fifo_uart_tx_if #(.FIFO_WIDTH(4)) if1 ();
  fifo_uart_tx_if #(.FIFO_WIDTH(3)) if2 ();

  fifo_uart_tx #(.FIFO_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo(if0),
    .tx(tx0), .busy(busy0), .frame_done(fd0));
  fifo_uart_tx #(.FIFO_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo(if1),
    .tx(tx1), .busy(busy1), .frame_done(fd1));
  fifo_uart_tx #(.FIFO_WIDTH(3), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .fifo(if2),
    .tx(tx2), .busy(busy2), .frame_done(fd2));

  // Behavioural FIFOs: registered read data, valid the cycle after a pop.
  logic [3:0] mem0 [0:63];
  logic [3:0] mem1 [0:63];
  logic [2:0] mem2 [0:63];
  int wr0 = 0, rd0 = 0, pops0 = 0;
  int wr1 = 0, rd1 = 0, pops1 = 0, last_pop1 = 0, prev_pop1 = 0;
  int wr2 = 0, rd2 = 0, pops2 = 0;
  logic [3:0] exp0 [$];
  logic [3:0] exp1 [$];
  logic [2:0] exp2 [$];

  assign if0.fifo_empty = (rd0 == wr0);
  assign if1.fifo_empty = (rd1 == wr1);
  assign if2.fifo_empty = (rd2 == wr2);

  always @(posedge clk) begin
    if (if0.fifo_rd_en) begin
      pops0 <= pops0 + 1;
      if (rd0 < wr0) begin
        if0.fifo_rd_data <= mem0[rd0];
        rd0 <= rd0 + 1;
      end
    end
    if (if1.fifo_rd_en) begin
      pops1 <= pops1 + 1;
      prev_pop1 <= last_pop1;
      last_pop1 <= cyc;
      if (rd1 < wr1) begin
        if1.fifo_rd_data <= mem1[rd1];
        rd1 <= rd1 + 1;
      end
    end
    if (if2.fifo_rd_en) begin
      pops2 <= pops2 + 1;
      if (rd2 < wr2) begin
        if2.fifo_rd_data <= mem2[rd2];
        rd2 <= rd2 + 1;
      end
    end
  end

  task automatic load0(input logic [3:0] w);
    mem0[wr0] = w; wr0++; exp0.push_back(w);
  endtask
  task automatic load1(input logic [3:0] w);
    mem1[wr1] = w; wr1++; exp1.push_back(w);
  endtask
  task automatic load2(input logic [2:0] w);
    mem2[wr2] = w; wr2++; exp2.push_back(w);
  endtask

  function automatic logic txs(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic fds(input int sel);
    case (sel)
      0: return fd0;
      1: return fd1;
      default: return fd2;
    endcase
  endfunction

  // Expected line levels, one entry per bit period, index 0 = start bit.
  function automatic logic [15:0] frame_bits(input logic [7:0] w, input int n, input bit par_en);
    logic [15:0] e = '0;
    bit p = 1'b0;
    for (int i = 0; i < n; i++) begin
      e[1+i] = w[i];
      p ^= w[i];
    end
    if (par_en) begin
      e[1+n] = p;
      e[2+n] = 1'b1;
    end else e[1+n] = 1'b1;
    return e;
  endfunction

  // Waits for a start bit, then captures nb bit periods of cpb cycles each.
  task automatic rx(input int sel, input int nb, input int cpb, input int drop_at,
                    output logic [15:0] bits, output bit glitch, output int fd_at,
                    output int fd_cnt, output int t_start, output bit tmo);
    bits = '0; glitch = 1'b0; fd_at = -1; fd_cnt = 0; t_start = 0; tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txs(sel) === 1'b0) begin
        tmo = 1'b0;
        break;
      end
    end
    if (tmo) return;
    t_start = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = txs(sel);
        else if (txs(sel) !== bits[b]) glitch = 1'b1;
        if (fds(sel) === 1'b1) begin
          fd_cnt++;
          fd_at = b * cpb + c + 1;
        end
        if (sel == 0 && drop_at == b * cpb + c + 1) en0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    en0 = 1'b1;
    load0(4'hA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.fifo_rd_en !== 1'b0)
        $display("FAIL reset_hold: tx=%b busy=%b rd_en=%b, required 1 0 0", tx0, busy0, if0.fifo_rd_en);
      else passes++;
    end
    rst_n = 1'b1;
    checks++;
    if (if0.fifo_rd_en !== 1'b0) $display("FAIL release_c1: rd_en=%b required 0", if0.fifo_rd_en);
    else passes++;
    @(negedge clk);
    checks++;
    if (if0.fifo_rd_en !== 1'b1 || busy0 !== 1'b1)
      $display("FAIL release_c2_pop: rd_en=%b busy=%b required 1 1", if0.fifo_rd_en, busy0);
    else passes++;
    @(negedge clk);
    checks++;
    if (if0.fifo_rd_en !== 1'b0) $display("FAIL pop_pulse_width: rd_en=%b required 0", if0.fifo_rd_en);
    else passes++;
  endtask

  task automatic test_single_word();
    logic [15:0] bits, e;
    bit g, tmo;
    int fa, fc, ts;
    rx(0, 6, 4, 0, bits, g, fa, fc, ts, tmo);
    checks++;
    if (tmo) $display("FAIL single_start: no start bit within bound");
    else passes++;
    e = frame_bits(8'(exp0.pop_front()), 4, 1'b0);
    checks++;
    if (bits !== e || g) $display("FAIL single_bits: got %h glitch=%0d required %h glitch=0", bits, g, e);
    else passes++;
    checks++;
    if (fa != 24 || fc != 1) $display("FAIL single_frame_done: at %0d count %0d required 24 1", fa, fc);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || fd0 !== 1'b0 || tx0 !== 1'b1)
      $display("FAIL single_after: busy=%b fd=%b tx=%b required 0 0 1", busy0, fd0, tx0);
    else passes++;
    checks++;
    if (pops0 != 1) $display("FAIL single_pops: got %0d required 1", pops0);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h9, 4'h6};
    logic [15:0] bits, e;
    bit g, tmo;
    int fa, fc, ts, prev;
    int base = pops0;
    prev = 0;
    for (int i = 0; i < 8; i++) load0(words[i]);
    for (int k = 0; k < 8; k++) begin
      rx(0, 6, 4, 0, bits, g, fa, fc, ts, tmo);
      e = frame_bits(8'(exp0.pop_front()), 4, 1'b0);
      checks++;
      if (tmo || bits !== e || g || fa != 24)
        $display("FAIL b2b_frame%0d: bits %h glitch %0d done_at %0d tmo %0d, required %h 0 24 0",
                 k, bits, g, fa, tmo, e);
      else passes++;
      if (k > 0) begin
        checks++;
        if (ts - prev != 27) $display("FAIL b2b_period%0d: got %0d required 27", k, ts - prev);
        else passes++;
      end
      prev = ts;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || tx0 !== 1'b1 || if0.fifo_empty !== 1'b1 || pops0 != base + 8)
      $display("FAIL b2b_drain: busy=%b tx=%b empty=%b pops=%0d required 0 1 1 %0d",
               busy0, tx0, if0.fifo_empty, pops0, base + 8);
    else passes++;
  endtask

  task automatic test_enable_drop();
    logic [15:0] bits, e;
    bit g, tmo, stray;
    int fa, fc, ts, prev;
    int base = pops0;
    load0(4'h3); load0(4'h6); load0(4'hE);
    rx(0, 6, 4, 10, bits, g, fa, fc, ts, tmo);
    e = frame_bits(8'(exp0.pop_front()), 4, 1'b0);
    checks++;
    if (tmo || bits !== e || g || fa != 24)
      $display("FAIL drop_frame1: bits %h glitch %0d done_at %0d required %h 0 24", bits, g, fa, e);
    else passes++;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if0.fifo_rd_en !== 1'b0 || busy0 !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray || pops0 != base + 1)
      $display("FAIL drop_no_pop: stray=%0d pops=%0d required 0 %0d", stray, pops0, base + 1);
    else passes++;
    en0 = 1'b1;
    prev = 0;
    for (int k = 0; k < 2; k++) begin
      rx(0, 6, 4, 0, bits, g, fa, fc, ts, tmo);
      e = frame_bits(8'(exp0.pop_front()), 4, 1'b0);
      checks++;
      if (tmo || bits !== e || g)
        $display("FAIL drop_resume%0d: bits %h glitch %0d tmo %0d required %h", k, bits, g, tmo, e);
      else passes++;
      if (k == 1) begin
        checks++;
        if (ts - prev != 27) $display("FAIL drop_resume_period: got %0d required 27", ts - prev);
        else passes++;
      end
      prev = ts;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pops0 != base + 3) $display("FAIL drop_pops: got %0d required %0d", pops0, base + 3);
    else passes++;
  endtask

  task automatic test_async_reset();
    logic [15:0] bits, e;
    bit g, tmo;
    int fa, fc, ts, base;
    logic [3:0] lost;
    load0(4'hC);
    tmo = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx0 === 1'b0) begin
        tmo = 1'b0;
        break;
      end
    end
    repeat (9) @(negedge clk);
    checks++;
    if (tmo || tx0 !== 1'b0 || busy0 !== 1'b1)
      $display("FAIL arst_pre: tmo=%0d tx=%b busy=%b required 0 0 1", tmo, tx0, busy0);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0)
      $display("FAIL arst_immediate: tx=%b busy=%b required 1 0", tx0, busy0);
    else passes++;
    lost = exp0.pop_front();
    load0(4'h9);
    base = pops0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rx(0, 6, 4, 0, bits, g, fa, fc, ts, tmo);
    e = frame_bits(8'(exp0.pop_front()), 4, 1'b0);
    checks++;
    if (tmo || bits !== e || g || fa != 24)
      $display("FAIL arst_fresh_frame: bits %h glitch %0d done_at %0d required %h (lost %h)",
               bits, g, fa, e, lost);
    else passes++;
    checks++;
    if (pops0 != base + 1) $display("FAIL arst_pops: got %0d required %0d", pops0, base + 1);
    else passes++;
  endtask

  task automatic test_parity();
    logic [15:0] bits, e;
    bit g, tmo;
    int fa, fc, ts, prev;
    en1 = 1'b1;
    load1(4'h7); load1(4'h3);
    prev = 0;
    for (int k = 0; k < 2; k++) begin
      rx(1, 7, 4, 0, bits, g, fa, fc, ts, tmo);
      e = frame_bits(8'(exp1.pop_front()), 4, 1'b1);
      checks++;
      if (tmo || bits !== e || g || fa != 28 || fc != 1)
        $display("FAIL parity_frame%0d: bits %h glitch %0d done_at %0d tmo %0d required %h 0 28 0",
                 k, bits, g, fa, tmo, e);
      else passes++;
      if (k == 1) begin
        checks++;
        if (ts - prev != 31) $display("FAIL parity_period: got %0d required 31", ts - prev);
        else passes++;
      end
      prev = ts;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pops1 != 2 || last_pop1 - prev_pop1 != 31 || busy1 !== 1'b0)
      $display("FAIL parity_pops: count %0d gap %0d busy %b required 2 31 0",
               pops1, last_pop1 - prev_pop1, busy1);
    else passes++;
  endtask

  task automatic test_one_clk_per_bit();
    logic [15:0] bits, e;
    bit g, tmo;
    int fa, fc, ts, prev;
    en2 = 1'b1;
    load2(3'b101); load2(3'b110); load2(3'b011);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      rx(2, 6, 1, 0, bits, g, fa, fc, ts, tmo);
      e = frame_bits(8'(exp2.pop_front()), 3, 1'b1);
      checks++;
      if (tmo || bits !== e || fa != 6 || fc != 1)
        $display("FAIL cpb1_frame%0d: bits %h done_at %0d count %0d tmo %0d required %h 6 1 0",
                 k, bits, fa, fc, tmo, e);
      else passes++;
      if (k > 0) begin
        checks++;
        if (ts - prev != 9) $display("FAIL cpb1_period%0d: got %0d required 9", k, ts - prev);
        else passes++;
      end
      prev = ts;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pops2 != 3 || busy2 !== 1'b0 || tx2 !== 1'b1)
      $display("FAIL cpb1_drain: pops %0d busy %b tx %b required 3 0 1", pops2, busy2, tx2);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_parity();
    test_one_clk_per_bit();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's synchronous FIFO. It pops FIFO_WIDTH-bit words whenever the FIFO is non-empty and enabled, and transmits each word as a UART-style serial frame: start bit, data LSB first, optional even parity, stop bit. It sits between the FIFO read port (rd_ena/rd_data/empty) and a single-bit output pin.

Parameters:
FIFO_WIDTH, 4, data word width popped from the FIFO and sent per frame (>=1)
CLKS_PER_BIT, 4, clk cycles per serial bit (>=1)
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  FIFO_WIDTH  FIFO read data, registered by the FIFO; valid the cycle after a pop
fifo_rd_en  output  1  FIFO pop request, one-cycle pulse
tx  output  1  serial line, idles high
busy  output  1  high whenever FSM is not in IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, all counters and the shift register cleared. Takes effect immediately, including mid-frame. A word popped but not fully sent is lost.
- tx, fifo_rd_en, and frame_done are registered. Each holds the value for the state occupied in that cycle.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to POP. Otherwise stay.
- POP (1 cycle): fifo_rd_en=1. If fifo_empty=1 in this cycle (defensive only), go to IDLE with no load. Otherwise go to LOAD.
- LOAD (1 cycle): shift register <= fifo_rd_data, parity bit <= ^fifo_rd_data. Then go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After FIFO_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: tx=even parity bit (XOR of data) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Then always go to IDLE.
- Counters:
  - baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; width = max(1, clog2(CLKS_PER_BIT)).
  - bit counter counts 0..FIFO_WIDTH-1; width = max(1, clog2(FIFO_WIDTH)).
- Frame length = (2 + FIFO_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles. Back-to-back frame period = frame length + 3 (IDLE, POP, LOAD). With defaults: 24-cycle frame, 27-cycle period.
- Exactly one fifo_rd_en pulse per frame. No pop ever occurs while busy in START..STOP.
- enable deasserted mid-frame: the current frame completes normally and no new pop is issued.
- enable changes outside IDLE are ignored.
- fifo_empty is ignored in every state except IDLE and POP.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle, and the counters must not underflow or skip.

Test Plan:
- Reset: hold rst_n=0 with enable=1 and fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout. Release -> fifo_rd_en pulses on the 2nd cycle after release (IDLE, then POP).
- Single word 4'hA, defaults: fifo_rd_data=4'hA after the pop -> tx sequence per 4-cycle bit is 0 (start), 0,1,0,1, 1 (stop). frame_done pulses at cycle 24 of the frame. busy falls the next cycle.
- PARITY_EN=1, words 4'h7 then 4'h3: parity bits 1 then 0. Each frame is 28 cycles. Exactly two fifo_rd_en pulses, 31 cycles apart.
- Back-to-back: FIFO preloaded with 8 words, enable=1 -> 8 frames, 8 pops, each start bit 27 cycles after the previous one (defaults). Stops when fifo_empty=1, tx=1, busy=0.
- enable dropped in the DATA state of frame 1 with words remaining -> frame 1 completes intact. No further fifo_rd_en. Re-asserting enable resumes with the next word.
- Async reset asserted in the DATA state mid-bit -> tx=1 and busy=0 in the same cycle, without waiting for a clk edge. After release with a non-empty FIFO, a fresh frame starts with a new pop.
